// File: rtl/seg_pkg.sv
// seg_pkg: shared 7-segment glyph constants (active-low, gfedcba), reader FSM states
// and the pattern-to-hex decode function used by the reader.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        SETTLE,
        STABLE,
        REPORT
    } seg_state_t;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] num;
    } seg_dec_t;

    // Unknown glyphs decode to err with num forced to 0.
    function automatic seg_dec_t seg_decode(input logic [6:0] pattern);
        seg_dec_t d;
        d = '{err: 1'b0, blank: 1'b0, num: 4'h0};
        case (pattern)
            SEG_0:     d.num = 4'h0;
            SEG_1:     d.num = 4'h1;
            SEG_2:     d.num = 4'h2;
            SEG_3:     d.num = 4'h3;
            SEG_4:     d.num = 4'h4;
            SEG_5:     d.num = 4'h5;
            SEG_6:     d.num = 4'h6;
            SEG_7:     d.num = 4'h7;
            SEG_8:     d.num = 4'h8;
            SEG_9:     d.num = 4'h9;
            SEG_A:     d.num = 4'hA;
            SEG_B:     d.num = 4'hB;
            SEG_C:     d.num = 4'hC;
            SEG_D:     d.num = 4'hD;
            SEG_E:     d.num = 4'hE;
            SEG_F:     d.num = 4'hF;
            SEG_BLANK: d.blank = 1'b1;
            default:   d.err = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_reader_if.sv
// seg_reader_if: decoded-token output port of the segment reader (valid/ready plus
// qualifiers and the sticky overrun flag).
interface seg_reader_if;
    logic [3:0] out_num;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;
    logic       out_blank;
    logic       overrun;

    modport master (
        output out_num, out_valid, out_err, out_blank, overrun,
        input  out_ready
    );

    modport slave (
        input  out_num, out_valid, out_err, out_blank, overrun,
        output out_ready
    );
endinterface

// File: rtl/seg_sync.sv
// seg_sync: per-bit 2-flop synchronizer for the asynchronous segment bus; resets to
// all segments off so the reader starts from the blank pattern.
module seg_sync
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] d,
    output logic [6:0] q
);

    logic [6:0] meta_reg;
    logic [6:0] sync_reg;

    for (genvar gi = 0; gi < 7; gi++) begin : g_bit
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                meta_reg[gi] <= SEG_BLANK[gi];
                sync_reg[gi] <= SEG_BLANK[gi];
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/seg_reader.sv
// seg_reader: waits for the synchronized segment bus to hold still, decodes new glyphs
// and offers them as valid/ready tokens. Macro SEG_READER_BLANK_EN reports blank as a token.
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [6:0]   seg_in,
    seg_reader_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef SEG_READER_BLANK_EN
    localparam logic BLANK_TOKEN = 1'b1;
`else
    localparam logic BLANK_TOKEN = 1'b0;
`endif

    logic [6:0]       s_seg;
    logic [6:0]       prev_reg;
    logic [6:0]       last_rep_reg;
    logic [CNT_W-1:0] cnt_reg;
    seg_state_t       state_reg;
    logic [3:0]       num_reg;
    logic             valid_reg;
    logic             err_reg;
    logic             blank_reg;
    logic             overrun_reg;

    logic     changed;
    logic     accept;
    logic     fresh;
    seg_dec_t dec;

    seg_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (seg_in),
        .q   (s_seg)
    );

    assign changed = (s_seg != prev_reg);
    assign accept  = !changed && (cnt_reg == CNT_LAST);
    assign fresh   = (s_seg != last_rep_reg);
    assign dec     = seg_decode(s_seg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg     <= SEG_BLANK;
            last_rep_reg <= SEG_BLANK;
            cnt_reg      <= '0;
            state_reg    <= SETTLE;
            num_reg      <= 4'h0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            blank_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            prev_reg <= s_seg;
            // Counter saturates at the accept point so a held pattern is not re-counted.
            if (changed) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                SETTLE: begin
                    if (accept) begin
                        if (!fresh) begin
                            state_reg <= STABLE;
                        end else begin
                            last_rep_reg <= s_seg;
                            if (dec.blank && !BLANK_TOKEN) begin
                                state_reg <= STABLE;
                            end else begin
                                num_reg   <= dec.num;
                                err_reg   <= dec.err;
                                blank_reg <= dec.blank && BLANK_TOKEN;
                                valid_reg <= 1'b1;
                                state_reg <= REPORT;
                            end
                        end
                    end
                end
                STABLE: begin
                    if (changed) begin
                        state_reg <= SETTLE;
                    end
                end
                REPORT: begin
                    if (accept && fresh) begin
                        overrun_reg <= 1'b1;
                    end
                    // A pattern still settling at handoff keeps counting in SETTLE.
                    if (bus.out_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= (changed || cnt_reg != CNT_LAST) ? SETTLE : STABLE;
                    end
                end
                default: state_reg <= SETTLE;
            endcase
        end
    end

    assign bus.out_num   = num_reg;
    assign bus.out_valid = valid_reg;
    assign bus.out_err   = err_reg;
    assign bus.out_blank = blank_reg;
    assign bus.overrun   = overrun_reg;

endmodule

// File: doc/seg_reader.md
# seg_reader

Reader-side counterpart to the team's hex-to-7-segment encoder. It samples an active-low 7-segment bus, such as a display-driver output looped back for self-test or a pattern from another board. It waits for the pattern to stay stable, decodes it back to a 4-bit hex value, and presents the result on a valid/ready output port. It sits between the display pins and any checker or scoreboard logic that must confirm what the display is showing.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 1–255.
- `CNT_W`, default 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.
- `clk` in, 1 bit: system clock, rising edge.
- `rst` in, 1 bit: asynchronous, active-low reset.
- `seg_in` in, 7 bits: segment bus, active-low, bit 6 = g … bit 0 = a; asynchronous to `clk`.
- `out_num` out, 4 bits: decoded hex value.
- `out_valid` out, 1 bit: a decoded token is presented.
- `out_ready` in, 1 bit: the consumer accepts the token.
- `out_err` out, 1 bit: qualifies `out_valid`; the pattern is not a recognized glyph, and `out_num` = 0.
- `out_blank` out, 1 bit: qualifies `out_valid`; the pattern is all-off (only with the macro).
- `overrun` out, 1 bit: sticky; a new stable pattern was lost while a token was pending.

## Operation
- A 2-flop synchronizer on `seg_in` produces `s_seg`. A `prev` register holds the previous `s_seg`. A `last_rep` register holds the last accepted pattern and resets to 7'b1111111.
- The FSM has three states: SETTLE, STABLE, REPORT. Reset state is SETTLE.
- SETTLE:
  - When `s_seg` != `prev`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches STABLE_CYCLES−1 with `s_seg` == `prev`, the pattern is accepted.
- On acceptance:
  - If the pattern == `last_rep`, go to STABLE and emit nothing.
  - Otherwise latch the decode result, update `last_rep`, and go to REPORT.
- STABLE: any `s_seg` != `prev` clears the counter and returns to SETTLE.
- REPORT: `out_valid` = 1, and outputs are held constant. On `out_valid` && `out_ready`, go to STABLE, or to SETTLE if `s_seg` changed during that cycle.
- While in REPORT, stability is still tracked. If a different pattern becomes accepted before the handshake:
  - `overrun` is set.
  - The new pattern is dropped.
  - `last_rep` is not updated.
- Decode table (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Any other pattern, except blank (1111111), yields `out_err` = 1 and `out_num` = 0.

## Timing
- Reset values:
  - `out_num` = 0, `out_valid` = 0, `out_err` = 0, `out_blank` = 0, `overrun` = 0.
  - Counter = 0, synchronizer flops = 7'b1111111.
- Reset asserted mid-REPORT drops the token immediately, asynchronously.
- Latency: `out_valid` rises exactly STABLE_CYCLES+2 `clk` edges after the edge at which the first synchronizer flop captures the new pattern.
- Any change on `s_seg` before the count completes restarts the full STABLE_CYCLES window.
- Handshake: the token transfers on a rising edge with `out_valid` && `out_ready`. `out_valid` falls on that edge. The earliest next token is STABLE_CYCLES+2 edges after the next pattern change. `out_ready` is ignored while `out_valid` = 0.
- The throughput limit is one token per pattern change.

## Configuration
- `SEG_READER_BLANK_EN` defined: an accepted blank pattern produces a token with `out_blank` = 1, `out_num` = 0, `out_err` = 0.
- `SEG_READER_BLANK_EN` undefined:
  - A blank pattern updates `last_rep` silently, with no token; the FSM goes to STABLE.
  - `out_blank` is tied to 0.

## Structure
- Shared package `seg_pkg`:
  - Pattern constants SEG_0 … SEG_F and SEG_BLANK.
  - FSM state typedef.
  - Function `seg_decode(pattern)` returning {err, blank, num}.
- The encoder side adopts the same constants.
- One sub-module, `seg_sync`: a 7-bit, 2-flop synchronizer with reset value 7'b1111111.

## Test plan
- `seg_in` = 0100100 held 20 cycles, `out_ready` = 1 → one token with `out_num` = 2, `out_err` = 0, valid exactly 6 edges after capture (STABLE_CYCLES = 4); no second token.
- Glitch `seg_in` = 0011001 for 3 cycles between steady 1111001 → one token `out_num` = 1 only; the glitch never reported.
- `seg_in` = 0110110 stable → token with `out_err` = 1, `out_num` = 0.
- `out_ready` = 0, sequence 3 (0110000), then 7 (1111000) held 10 cycles → token 3 held; `overrun` = 1; 7 dropped. After `out_ready` = 1, pattern 7 is re-reported only if it later changes to something different from 3.
- Reset pulsed low mid-REPORT → all outputs 0 within the same cycle; after release the held pattern is re-reported after the full latency.
- Blank 1111111 after 8 → with the macro: token `out_blank` = 1; without: no token, and a subsequent 8 is reported again.
